// File: rtl/msg_deframer_if.sv
// ----------------------------------------------------------------------------
// msg_deframer_if
// Groups the word stream coming from the message-receive stage (enq*) and the
// assembled-message record handed to method dispatch (out*).
//
// Handshakes:
//   enq : a word moves on a rising CLK edge when enq__ENA && enq__RDY.
//         enq_last is qualified by enq__ENA. enq__RDY never depends on
//         enq__ENA, and a word offered while enq__RDY=0 is ignored.
//   out : a message moves on a rising CLK edge when out_valid && out_ready.
//         All out_* fields stay stable while out_valid is high and unaccepted.
//
// Modports:
//   master : the upstream producer plus the downstream consumer.
//   slave  : the deframer.
// ----------------------------------------------------------------------------
interface msg_deframer_if #(
  parameter int WIDTH     = 32,
  parameter int MAX_WORDS = 8
);
  localparam int LW = $clog2(MAX_WORDS + 1);

  logic                       enq__ENA;
  logic [WIDTH-1:0]           enq_v;
  logic                       enq_last;
  logic                       enq__RDY;

  logic                       out_valid;
  logic                       out_ready;
  logic [15:0]                out_id;
  logic [15:0]                out_hlen;
  logic [LW-1:0]              out_len;
  logic [MAX_WORDS*WIDTH-1:0] out_data;
  logic                       out_err;

  modport master (
    output enq__ENA, enq_v, enq_last, out_ready,
    input  enq__RDY, out_valid, out_id, out_hlen, out_len, out_data, out_err
  );

  modport slave (
    input  enq__ENA, enq_v, enq_last, out_ready,
    output enq__RDY, out_valid, out_id, out_hlen, out_len, out_data, out_err
  );
endinterface

// File: rtl/msg_deframer.sv
// ----------------------------------------------------------------------------
// msg_deframer
// Reassembles a framed word stream into one wide record. Word 0 of each
// message is a header (id in [31:16], declared payload length in [15:0]).
// The following words fill payload slots 0..MAX_WORDS-1. Words beyond the
// slot count are dropped and flagged. Once the last word arrives, the record
// is held on out_* with out_valid=1 until the consumer takes it. Input is
// stalled during that time.
//
// Ports:
//   CLK          clock
//   nRST         synchronous reset, active-high
//   bus          msg_deframer_if.slave (enq word stream + out record)
//   dbg_state_o  current FSM state (0=HDR, 1=BODY, 2=HOLD)
// ----------------------------------------------------------------------------
module msg_deframer #(
  parameter int WIDTH     = 32,
  parameter int MAX_WORDS = 8
) (
  input  logic                 CLK,
  input  logic                 nRST,
  msg_deframer_if.slave        bus,
  output logic [1:0]           dbg_state_o
);
  localparam int LW = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    BODY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [15:0]                id_q, id_d;
  logic [15:0]                hlen_q, hlen_d;
  logic [LW-1:0]              cnt_q, cnt_d;
  logic [15:0]                rcv_q, rcv_d;    // full received payload count
  logic                       ovf_q, ovf_d;
  logic [MAX_WORDS*WIDTH-1:0] data_q, data_d;

  logic accept;

  // Ready comes from state only, so the producer never sees a loop via ENA.
  assign bus.enq__RDY = (state_q != HOLD);
  assign accept       = bus.enq__ENA && bus.enq__RDY;

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q <= HDR;
      id_q    <= '0;
      hlen_q  <= '0;
      cnt_q   <= '0;
      rcv_q   <= '0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      hlen_q  <= hlen_d;
      cnt_q   <= cnt_d;
      rcv_q   <= rcv_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    hlen_d  = hlen_q;
    cnt_d   = cnt_q;
    rcv_d   = rcv_q;
    ovf_d   = ovf_q;
    data_d  = data_q;

    case (state_q)
      HDR: begin
        if (accept) begin
          id_d    = bus.enq_v[31:16];
          hlen_d  = bus.enq_v[15:0];
          cnt_d   = '0;
          rcv_d   = '0;
          ovf_d   = 1'b0;
          data_d  = '0;
          state_d = bus.enq_last ? HOLD : BODY;
        end
      end
      BODY: begin
        if (accept) begin
          if (cnt_q < LW'(MAX_WORDS)) begin
            // Decode the slot index instead of using a variable
            // part-select.
            for (int k = 0; k < MAX_WORDS; k++) begin
              if (cnt_q == LW'(k)) begin
                data_d[k*WIDTH +: WIDTH] = bus.enq_v;
              end
            end
            cnt_d = cnt_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
          if (rcv_q != 16'hFFFF) begin
            rcv_d = rcv_q + 16'd1;
          end
          if (bus.enq_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // No bypass: ready stays low during the accepting cycle.
        if (bus.out_ready) begin
          state_d = HDR;
        end
      end
      default: state_d = HDR;
    endcase
  end

  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_id    = id_q;
  assign bus.out_hlen  = hlen_q;
  assign bus.out_len   = cnt_q;
  assign bus.out_data  = data_q;
  // Flag an overflow, or a mismatch between the declared and received lengths.
  assign bus.out_err   = ovf_q || (hlen_q != rcv_q);
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_msg_deframer.sv
// ----------------------------------------------------------------------------
// tb_msg_deframer
// Directed bench for msg_deframer. Inputs change #1 after the rising edge.
// Outputs are compared at the same point, away from the edge.
// ----------------------------------------------------------------------------
module tb_msg_deframer;
  localparam int WIDTH     = 32;
  localparam int MAX_WORDS = 8;
  localparam int DW        = MAX_WORDS * WIDTH;

  typedef logic [DW-1:0] cv_t;

  logic       CLK;
  logic       nRST;
  logic [1:0] dbg_state;

  int n_vec;
  int n_err;

  logic [WIDTH-1:0] exp_q[$];

  msg_deframer_if #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) bus ();

  msg_deframer #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic do_reset();
    nRST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input cv_t got, input cv_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Builds the expected out_data from the first MAX_WORDS queued payload words.
  function automatic cv_t exp_data_from_q();
    cv_t d;
    d = '0;
    for (int i = 0; i < exp_q.size() && i < MAX_WORDS; i++) begin
      d[i*WIDTH +: WIDTH] = exp_q[i];
    end
    return d;
  endfunction

  task automatic check_msg(input string tag, input logic [15:0] id,
                           input logic [15:0] hlen, input int len,
                           input cv_t data, input logic err);
    check_eq({tag, "_valid"}, cv_t'(bus.out_valid), cv_t'(1'b1));
    check_eq({tag, "_rdy"},   cv_t'(bus.enq__RDY), cv_t'(1'b0));
    check_eq({tag, "_id"},    cv_t'(bus.out_id), cv_t'(id));
    check_eq({tag, "_hlen"},  cv_t'(bus.out_hlen), cv_t'(hlen));
    check_eq({tag, "_len"},   cv_t'(bus.out_len), cv_t'(len));
    check_eq({tag, "_data"},  bus.out_data, data);
    check_eq({tag, "_err"},   cv_t'(bus.out_err), cv_t'(err));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_state"}, cv_t'(dbg_state), cv_t'(0));
    check_eq({tag, "_rdy"},   cv_t'(bus.enq__RDY), cv_t'(1'b1));
    check_eq({tag, "_valid"}, cv_t'(bus.out_valid), cv_t'(1'b0));
    check_eq({tag, "_id"},    cv_t'(bus.out_id), cv_t'(0));
    check_eq({tag, "_hlen"},  cv_t'(bus.out_hlen), cv_t'(0));
    check_eq({tag, "_len"},   cv_t'(bus.out_len), cv_t'(0));
    check_eq({tag, "_data"},  bus.out_data, cv_t'(0));
    check_eq({tag, "_err"},   cv_t'(bus.out_err), cv_t'(0));
  endtask

  // ---------------- drivers ----------------
  task automatic send_word(input logic [WIDTH-1:0] w, input logic last);
    int n;
    n = 0;
    while (!bus.enq__RDY && n < 50) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check_eq("rdy_wait", cv_t'(bus.enq__RDY), cv_t'(1'b1));
    bus.enq__ENA = 1'b1;
    bus.enq_v    = w;
    bus.enq_last = last;
    @(posedge CLK);
    #1;
    bus.enq__ENA = 1'b0;
    bus.enq_last = 1'b0;
  endtask

  task automatic consume();
    int n;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check_eq("valid_wait", cv_t'(bus.out_valid), cv_t'(1'b1));
    bus.out_ready = 1'b1;
    @(posedge CLK);
    #1;
    bus.out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cv_t d;
    n_vec = 0;
    n_err = 0;
    bus.enq__ENA  = 1'b0;
    bus.enq_v     = '0;
    bus.enq_last  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    do_reset();
    check_idle("rst");

    // Two-word message with idle cycles in BODY
    exp_q.push_back(32'h11111111);
    exp_q.push_back(32'h22222222);
    send_word(32'h0005_0002, 1'b0);
    send_word(32'h11111111, 1'b0);
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    check_eq("m1_idle_state", cv_t'(dbg_state), cv_t'(1));
    check_eq("m1_idle_len",   cv_t'(bus.out_len), cv_t'(1));
    check_eq("m1_pre_valid",  cv_t'(bus.out_valid), cv_t'(1'b0));
    send_word(32'h22222222, 1'b1);
    d = exp_data_from_q();
    check_msg("m1", 16'h0005, 16'h0002, 2, d, 1'b0);
    check_eq("m1_state", cv_t'(dbg_state), cv_t'(2));

    // Backpressure: a header is offered while the message is held
    bus.enq__ENA  = 1'b1;
    bus.enq_v     = 32'h0003_0001;
    bus.enq_last  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check_eq("bp_rdy",  cv_t'(bus.enq__RDY), cv_t'(1'b0));
      check_eq("bp_id",   cv_t'(bus.out_id), cv_t'(16'h0005));
      check_eq("bp_data", bus.out_data, d);
    end
    @(posedge CLK);
    #1;
    bus.out_ready = 1'b1;
    @(posedge CLK);
    #1;
    bus.out_ready = 1'b0;
    check_eq("bp_rel_state", cv_t'(dbg_state), cv_t'(0));
    check_eq("bp_rel_rdy",   cv_t'(bus.enq__RDY), cv_t'(1'b1));
    check_eq("bp_rel_valid", cv_t'(bus.out_valid), cv_t'(1'b0));
    check_eq("bp_rel_id",    cv_t'(bus.out_id), cv_t'(16'h0005));
    @(posedge CLK);
    #1;
    bus.enq__ENA = 1'b0;
    check_eq("bp_hdr_state", cv_t'(dbg_state), cv_t'(1));
    check_eq("bp_hdr_id",    cv_t'(bus.out_id), cv_t'(16'h0003));
    check_eq("bp_hdr_hlen",  cv_t'(bus.out_hlen), cv_t'(16'h0001));
    check_eq("bp_hdr_data",  bus.out_data, cv_t'(0));
    check_eq("bp_hdr_len",   cv_t'(bus.out_len), cv_t'(0));
    send_word(32'h33333333, 1'b1);
    d = '0;
    d[31:0] = 32'h33333333;
    check_msg("m3", 16'h0003, 16'h0001, 1, d, 1'b0);
    consume();
    exp_q.delete();

    // Header-only message
    send_word(32'h0009_0000, 1'b1);
    check_msg("hdr_only", 16'h0009, 16'h0000, 0, cv_t'(0), 1'b0);
    consume();

    // Overflow: 10 words into 8 slots
    send_word(32'h0001_000A, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      exp_q.push_back(WIDTH'(i));
      send_word(WIDTH'(i), (i == 10));
    end
    d = exp_data_from_q();
    exp_q.delete();
    check_msg("ovf", 16'h0001, 16'h000A, 8, d, 1'b1);
    consume();

    // Short message: declares 3, sends 2
    send_word(32'h0004_0003, 1'b0);
    send_word(32'h000000A1, 1'b0);
    send_word(32'h000000A2, 1'b1);
    d = '0;
    d[31:0]  = 32'h000000A1;
    d[63:32] = 32'h000000A2;
    check_msg("short", 16'h0004, 16'h0003, 2, d, 1'b1);
    consume();

    // Reset mid-message, with a transfer offered on the reset edge
    send_word(32'h0007_0004, 1'b0);
    send_word(32'h0000BEEF, 1'b0);
    send_word(32'h0000CAFE, 1'b0);
    bus.enq__ENA = 1'b1;
    bus.enq_v    = 32'hDEADBEEF;
    bus.enq_last = 1'b1;
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    bus.enq__ENA = 1'b0;
    bus.enq_last = 1'b0;
    check_idle("midrst");

    // Fresh message after the reset
    send_word(32'h0002_0001, 1'b0);
    send_word(32'hAAAA5555, 1'b1);
    d = '0;
    d[31:0] = 32'hAAAA5555;
    check_msg("post_rst", 16'h0002, 16'h0001, 1, d, 1'b0);
    consume();
    check_eq("end_state", cv_t'(dbg_state), cv_t'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
